// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wb_pkg
// Description : Shared widths, FIFO entry type and match helper for writeback.
// Revision    : 1.0 - initial release
// ============================================================================
package wb_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;

    typedef struct packed {
        logic              live;
        logic [ADDR_W-1:0] waddr;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    function automatic logic entryMatch(input wb_entry_t e, input logic [ADDR_W-1:0] addr);
        return e.live && (e.waddr == addr);
    endfunction

endpackage
`default_nettype wire

// File: rtl/wb_mem_fifo.sv
`default_nettype none
// ============================================================================
// Module      : wb_mem_fifo
// Description : Load-result FIFO with per-entry squash by address and pending
//               register match outputs.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_mem_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              push,
    input  wb_entry_t         pushEntry,
    input  logic              pop,
    input  logic              squashEn,
    input  logic [ADDR_W-1:0] squashAddr,
    output wb_entry_t         head,
    output logic              full,
    output logic              empty,
    input  logic [ADDR_W-1:0] raddrA,
    input  logic [ADDR_W-1:0] raddrB,
    output logic              pendA,
    output logic              pendB
);

    localparam int c_ptrW = $clog2(DEPTH);
    localparam logic [c_ptrW:0] c_depth = (c_ptrW + 1)'(DEPTH);

    wb_entry_t         r_mem [DEPTH];
    logic [c_ptrW-1:0] r_wrPtr;
    logic [c_ptrW-1:0] r_rdPtr;
    logic [c_ptrW:0]   r_count;

    logic              w_doPush;
    logic              w_doPop;
    wb_entry_t         w_pushEntry;
    logic [DEPTH-1:0]  w_matchA;
    logic [DEPTH-1:0]  w_matchB;

    assign full     = (r_count == c_depth);
    assign empty    = (r_count == '0);
    assign head     = r_mem[r_rdPtr];
    assign w_doPush = push && !full;
    assign w_doPop  = pop && !empty;

    // A load arriving alongside a same-register squash is the older write.
    always_comb begin
        w_pushEntry      = pushEntry;
        w_pushEntry.live = pushEntry.live && !(squashEn && (pushEntry.waddr == squashAddr));
    end

    // Popped slots drop their live bit so live alone marks a queued entry.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squashEn && (r_mem[i].waddr == squashAddr)) begin
                    r_mem[i].live <= 1'b0;
                end
            end
            if (w_doPop) begin
                r_mem[r_rdPtr].live <= 1'b0;
                r_rdPtr             <= r_rdPtr + 1'b1;
            end
            if (w_doPush) begin
                r_mem[r_wrPtr] <= w_pushEntry;
                r_wrPtr        <= r_wrPtr + 1'b1;
            end
            case ({w_doPush, w_doPop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    generate
        for (genvar i = 0; i < DEPTH; i++) begin : g_match
            assign w_matchA[i] = entryMatch(r_mem[i], raddrA);
            assign w_matchB[i] = entryMatch(r_mem[i], raddrB);
        end
    endgenerate

    assign pendA = |w_matchA;
    assign pendB = |w_matchB;

endmodule
`default_nettype wire

// File: rtl/wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter
// Description : Writeback arbiter owning the register-file write port; merges
//               ALU and load results in program order. Macro WB_FWD_EN enables
//               the bypass outputs (tied to zero otherwise).
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 3
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              AluValid,
    output logic              AluReady,
    input  logic [ADDR_W-1:0] AluWaddr,
    input  logic [DATA_W-1:0] AluData,
    input  logic              MemValid,
    output logic              MemReady,
    input  logic [ADDR_W-1:0] MemWaddr,
    input  logic [DATA_W-1:0] MemData,
    output logic              WriteEn,
    output logic [ADDR_W-1:0] Waddr,
    output logic [DATA_W-1:0] DataIn,
    input  logic [ADDR_W-1:0] RaddrA,
    input  logic [ADDR_W-1:0] RaddrB,
    output logic              FwdHitA,
    output logic              FwdHitB,
    output logic [DATA_W-1:0] FwdDataA,
    output logic [DATA_W-1:0] FwdDataB,
    output logic              PendA,
    output logic              PendB
);

    localparam int c_cntW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [c_cntW-1:0] c_starveMax = c_cntW'(STARVE_LIMIT);

    wb_entry_t         w_head;
    wb_entry_t         w_pushEntry;
    logic              w_full;
    logic              w_empty;
    logic              w_aluFire;
    logic              w_memFire;
    logic              w_pop;

    logic [c_cntW-1:0] r_starveCnt;
    logic              r_writeEn;
    logic [ADDR_W-1:0] r_waddr;
    logic [DATA_W-1:0] r_dataIn;

    assign AluReady    = (r_starveCnt != c_starveMax);
    assign MemReady    = !w_full;
    assign w_aluFire   = AluValid && AluReady;
    assign w_memFire   = MemValid && MemReady;
    assign w_pop       = !w_aluFire && !w_empty;
    assign w_pushEntry = {1'b1, MemWaddr, MemData};

    wb_mem_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .Clk        (Clk),
        .Reset      (Reset),
        .push       (w_memFire),
        .pushEntry  (w_pushEntry),
        .pop        (w_pop),
        .squashEn   (w_aluFire),
        .squashAddr (AluWaddr),
        .head       (w_head),
        .full       (w_full),
        .empty      (w_empty),
        .raddrA     (RaddrA),
        .raddrB     (RaddrB),
        .pendA      (PendA),
        .pendB      (PendB)
    );

    // ALU wins unless the starve counter has forced AluReady low.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_writeEn <= 1'b0;
            r_waddr   <= '0;
            r_dataIn  <= '0;
        end else if (w_aluFire) begin
            r_writeEn <= 1'b1;
            r_waddr   <= AluWaddr;
            r_dataIn  <= AluData;
        end else if (w_pop && w_head.live) begin
            r_writeEn <= 1'b1;
            r_waddr   <= w_head.waddr;
            r_dataIn  <= w_head.data;
        end else begin
            r_writeEn <= 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            r_starveCnt <= '0;
        end else if (w_empty || w_pop) begin
            r_starveCnt <= '0;
        end else if (w_head.live) begin
            r_starveCnt <= r_starveCnt + 1'b1;
        end
    end

    assign WriteEn = r_writeEn;
    assign Waddr   = r_waddr;
    assign DataIn  = r_dataIn;

`ifdef WB_FWD_EN
    assign FwdHitA  = r_writeEn && (r_waddr == RaddrA);
    assign FwdHitB  = r_writeEn && (r_waddr == RaddrB);
    assign FwdDataA = FwdHitA ? r_dataIn : '0;
    assign FwdDataB = FwdHitB ? r_dataIn : '0;
`else
    assign FwdHitA  = 1'b0;
    assign FwdHitB  = 1'b0;
    assign FwdDataA = '0;
    assign FwdDataB = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter
// Description : Randomised self-checking bench for wb_arbiter against a
//               queue-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter;
    import wb_pkg::*;

    localparam int DEPTH        = 2;
    localparam int STARVE_LIMIT = 3;

    logic              Clk;
    logic              Reset;
    logic              AluValid;
    logic              AluReady;
    logic [ADDR_W-1:0] AluWaddr;
    logic [DATA_W-1:0] AluData;
    logic              MemValid;
    logic              MemReady;
    logic [ADDR_W-1:0] MemWaddr;
    logic [DATA_W-1:0] MemData;
    logic              WriteEn;
    logic [ADDR_W-1:0] Waddr;
    logic [DATA_W-1:0] DataIn;
    logic [ADDR_W-1:0] RaddrA;
    logic [ADDR_W-1:0] RaddrB;
    logic              FwdHitA;
    logic              FwdHitB;
    logic [DATA_W-1:0] FwdDataA;
    logic [DATA_W-1:0] FwdDataB;
    logic              PendA;
    logic              PendB;

    wb_arbiter #(
        .DEPTH        (DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .AluValid (AluValid),
        .AluReady (AluReady),
        .AluWaddr (AluWaddr),
        .AluData  (AluData),
        .MemValid (MemValid),
        .MemReady (MemReady),
        .MemWaddr (MemWaddr),
        .MemData  (MemData),
        .WriteEn  (WriteEn),
        .Waddr    (Waddr),
        .DataIn   (DataIn),
        .RaddrA   (RaddrA),
        .RaddrB   (RaddrB),
        .FwdHitA  (FwdHitA),
        .FwdHitB  (FwdHitB),
        .FwdDataA (FwdDataA),
        .FwdDataB (FwdDataB),
        .PendA    (PendA),
        .PendB    (PendB)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference model: queued loads in arrival order plus the write-port state.
    typedef struct {
        bit live;
        int waddr;
        int data;
    } ref_t;

    ref_t refQ[$];
    int   refStarve;
    bit   refWe;
    int   refWaddr;
    int   refData;

    int nVectors     = 0;
    int nMiscompares = 0;

    task automatic checkVal(input string tag, input logic [7:0] got, input logic [7:0] exp);
        nVectors++;
        if (got !== exp) begin
            nMiscompares++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit refPend(input int ra);
        foreach (refQ[i]) begin
            if (refQ[i].live && refQ[i].waddr == ra) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit refHit(input int ra);
`ifdef WB_FWD_EN
        return refWe && (refWaddr == ra);
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelReset();
        refQ.delete();
        refStarve = 0;
        refWe     = 1'b0;
        refWaddr  = 0;
        refData   = 0;
    endtask

    task automatic modelEdge(input bit alv, input int aw, input int ad,
                             input bit mv, input int mw, input int md, input bit rst);
        bit   aluFire;
        bit   memFire;
        bit   wasEmpty;
        bit   headLive;
        ref_t h;
        ref_t e;
        if (!rst) begin
            modelReset();
            return;
        end
        aluFire  = alv && (refStarve != STARVE_LIMIT);
        memFire  = mv && (refQ.size() < DEPTH);
        wasEmpty = (refQ.size() == 0);
        headLive = !wasEmpty && refQ[0].live;
        if (aluFire) begin
            refWe    = 1'b1;
            refWaddr = aw;
            refData  = ad;
            foreach (refQ[i]) begin
                if (refQ[i].waddr == aw) refQ[i].live = 1'b0;
            end
        end else if (!wasEmpty) begin
            h = refQ.pop_front();
            if (h.live) begin
                refWe    = 1'b1;
                refWaddr = h.waddr;
                refData  = h.data;
            end else begin
                refWe = 1'b0;
            end
        end else begin
            refWe = 1'b0;
        end
        if (wasEmpty || !aluFire) refStarve = 0;
        else if (headLive) refStarve++;
        if (memFire) begin
            e.live  = !(aluFire && aw == mw);
            e.waddr = mw;
            e.data  = md;
            refQ.push_back(e);
        end
    endtask

    task automatic checkOutputs(input int ra, input int rb);
        checkVal("AluReady", 8'(AluReady), 8'(refStarve != STARVE_LIMIT));
        checkVal("MemReady", 8'(MemReady), 8'(refQ.size() < DEPTH));
        checkVal("WriteEn",  8'(WriteEn),  8'(refWe));
        checkVal("Waddr",    8'(Waddr),    8'(refWaddr));
        checkVal("DataIn",   DataIn,       8'(refData));
        checkVal("PendA",    8'(PendA),    8'(refPend(ra)));
        checkVal("PendB",    8'(PendB),    8'(refPend(rb)));
        checkVal("FwdHitA",  8'(FwdHitA),  8'(refHit(ra)));
        checkVal("FwdHitB",  8'(FwdHitB),  8'(refHit(rb)));
        checkVal("FwdDataA", FwdDataA,     refHit(ra) ? 8'(refData) : 8'd0);
        checkVal("FwdDataB", FwdDataB,     refHit(rb) ? 8'(refData) : 8'd0);
    endtask

    // Apply one cycle of inputs, check outputs before the edge, then advance the model.
    task automatic step(input bit alv, input int aw, input int ad,
                        input bit mv, input int mw, input int md,
                        input bit rst, input int ra, input int rb);
        AluValid = alv;
        AluWaddr = 3'(aw);
        AluData  = 8'(ad);
        MemValid = mv;
        MemWaddr = 3'(mw);
        MemData  = 8'(md);
        Reset    = rst;
        RaddrA   = 3'(ra);
        RaddrB   = 3'(rb);
        #1;
        checkOutputs(ra, rb);
        @(posedge Clk);
        modelEdge(alv, aw, ad, mv, mw, md, rst);
        #1;
    endtask

    task automatic idle(input int n, input int ra, input int rb);
        for (int k = 0; k < n; k++) step(0, 0, 0, 0, 0, 0, 1, ra, rb);
    endtask

    initial begin
        int  aluPct;
        int  memPct;
        int  addrMax;
        bit  alv;
        bit  mv;
        bit  rst;

        AluValid = 1'b0;
        AluWaddr = '0;
        AluData  = '0;
        MemValid = 1'b0;
        MemWaddr = '0;
        MemData  = '0;
        RaddrA   = '0;
        RaddrB   = '0;
        Reset    = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        modelReset();

        // ALU write then bypass read of the same register
        step(1, 2, 22, 0, 0, 0, 1, 2, 0);
        idle(1, 2, 2);

        // Load visible as pending, then written two cycles after acceptance
        step(0, 0, 0, 1, 3, 16, 1, 3, 3);
        idle(2, 3, 3);

        // Younger ALU write squashes a queued load
        step(0, 0, 0, 1, 1, 8, 1, 1, 1);
        step(1, 1, 15, 0, 0, 0, 1, 1, 1);
        idle(3, 1, 1);

        // Same-cycle load and ALU write to one register
        step(1, 7, 5, 1, 7, 9, 1, 7, 7);
        idle(3, 7, 7);

        // Starvation: ALU held high while two loads wait
        step(1, 0, 100, 1, 4, 1, 1, 4, 5);
        step(1, 0, 101, 1, 5, 2, 1, 4, 5);
        for (int k = 0; k < 10; k++) step(1, 0, 102 + k, 0, 0, 0, 1, 4, 5);
        idle(2, 4, 5);

        // Reset mid-stream with two loads queued
        step(0, 0, 0, 1, 6, 33, 1, 6, 2);
        step(1, 0, 44, 1, 2, 55, 1, 6, 2);
        step(1, 0, 45, 0, 0, 0, 0, 6, 2);
        idle(4, 6, 2);

        // Random traffic in phases of varying pressure and address aliasing
        for (int c = 0; c < 3000; c++) begin
            case ((c / 300) % 4)
                0:       begin aluPct = 50; memPct = 50; addrMax = 7; end
                1:       begin aluPct = 90; memPct = 70; addrMax = 1; end
                2:       begin aluPct = 20; memPct = 80; addrMax = 2; end
                default: begin aluPct = 95; memPct = 30; addrMax = 7; end
            endcase
            alv = ($urandom_range(0, 99) < aluPct);
            mv  = ($urandom_range(0, 99) < memPct);
            rst = ($urandom_range(0, 99) != 0);
            step(alv, int'($urandom_range(0, addrMax)), int'($urandom_range(0, 255)),
                 mv,  int'($urandom_range(0, addrMax)), int'($urandom_range(0, 255)),
                 rst, int'($urandom_range(0, addrMax)), int'($urandom_range(0, addrMax)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
`default_nettype wire
